// File: rtl/maxnet_if.sv
// Handshake and data bundle between a Maxnet engine and its controller.
interface maxnet_if #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int EPS_FRAC = 8,
  parameter int ITER_W   = 16
);
  localparam int IDX_W = $clog2(N);

  logic                start;
  logic                abort;
  logic [EPS_FRAC-1:0] eps;
  logic [N*W-1:0]      in_vec;
  logic                ready;
  logic                done;
  logic                win_valid;
  logic [IDX_W-1:0]    win_idx;
  logic [W-1:0]        win_val;
  logic [ITER_W-1:0]   iter_count;
  logic                timeout;
  logic [N*W-1:0]      act_vec;

  modport master (
    output start, abort, eps, in_vec,
    input  ready, done, win_valid, win_idx, win_val, iter_count, timeout, act_vec
  );

  modport slave (
    input  start, abort, eps, in_vec,
    output ready, done, win_valid, win_idx, win_val, iter_count, timeout, act_vec
  );
endinterface

// File: rtl/maxnet_engine.sv
// Maxnet winner-take-all engine: iterates lateral inhibition until at most one channel survives.
// Optional iteration limit and timeout reporting enabled by defining MAXNET_TIMEOUT_EN.
module maxnet_engine #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int EPS_FRAC = 8,
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 255
) (
  input  logic     clk,
  input  logic     rst,
  maxnet_if.slave  io_mn
);
  localparam int IDX_W  = $clog2(N);
  localparam int SUM_W  = W + IDX_W;
  localparam int PROD_W = SUM_W + EPS_FRAC;

  if (N < 2 || MAX_ITER >= 2**ITER_W) begin : g_param_check
    $error("maxnet_engine: N must be >= 2 and MAX_ITER < 2**ITER_W");
  end

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_UPDATE, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [W-1:0]        r_act [N];
  logic [EPS_FRAC-1:0] r_eps;
  logic [ITER_W-1:0]   r_iter;
  logic                r_win_valid;
  logic [IDX_W-1:0]    r_win_idx;
  logic [W-1:0]        r_win_val;
  logic                r_timeout;

  logic [SUM_W-1:0]    w_total;
  logic [IDX_W:0]      w_nz_cnt;
  logic [W-1:0]        w_max;
  logic [IDX_W-1:0]    w_max_idx;
  logic [W-1:0]        w_new [N];
  logic                w_limit;
  logic [N*W-1:0]      w_act_flat;

  // One inhibition step: subtract the truncated scaled neighbour sum, clamped at zero.
  function automatic logic [W-1:0] inhibit(input logic [W-1:0]        a,
                                           input logic [SUM_W-1:0]    s,
                                           input logic [EPS_FRAC-1:0] e);
    logic [PROD_W-1:0] prod;
    logic [SUM_W-1:0]  p;
    prod = PROD_W'(s) * PROD_W'(e);
    p    = prod[PROD_W-1:EPS_FRAC];
    return (p >= SUM_W'(a)) ? '0 : (a - p[W-1:0]);
  endfunction

  // Strict '>' keeps the lowest index among equal maxima; an all-zero vector yields idx 0, val 0.
  always_comb begin
    w_total   = '0;
    w_nz_cnt  = '0;
    w_max     = '0;
    w_max_idx = '0;
    for (int i = 0; i < N; i++) begin
      w_total = w_total + SUM_W'(r_act[i]);
      if (r_act[i] != '0) w_nz_cnt = w_nz_cnt + (IDX_W+1)'(1);
      if (r_act[i] > w_max) begin
        w_max     = r_act[i];
        w_max_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_new[i] = inhibit(r_act[i], w_total - SUM_W'(r_act[i]), r_eps);
    end
  end

`ifdef MAXNET_TIMEOUT_EN
  assign w_limit = (r_iter == ITER_W'(MAX_ITER));
`else
  assign w_limit = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (io_mn.start) w_next = S_CHECK;
      S_CHECK: begin
        if (io_mn.abort)                        w_next = S_IDLE;
        else if (w_nz_cnt <= (IDX_W+1)'(1))     w_next = S_DONE;
        else if (w_limit)                       w_next = S_DONE;
        else                                    w_next = S_UPDATE;
      end
      S_UPDATE: w_next = io_mn.abort ? S_IDLE : S_CHECK;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_eps       <= '0;
      r_iter      <= '0;
      r_win_valid <= 1'b0;
      r_win_idx   <= '0;
      r_win_val   <= '0;
      r_timeout   <= 1'b0;
      for (int i = 0; i < N; i++) r_act[i] <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (io_mn.start) begin
          for (int i = 0; i < N; i++) r_act[i] <= io_mn.in_vec[i*W +: W];
          r_eps       <= io_mn.eps;
          r_iter      <= '0;
          r_win_valid <= 1'b0;
          r_win_idx   <= '0;
          r_win_val   <= '0;
          r_timeout   <= 1'b0;
        end
        S_CHECK: if (w_next == S_DONE) begin
          r_win_valid <= (w_nz_cnt == (IDX_W+1)'(1)) || w_limit;
          r_win_idx   <= w_max_idx;
          r_win_val   <= w_max;
          r_timeout   <= w_limit && (w_nz_cnt > (IDX_W+1)'(1));
        end
        S_UPDATE: if (!io_mn.abort) begin
          for (int i = 0; i < N; i++) r_act[i] <= w_new[i];
          r_iter <= r_iter + ITER_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_act_flat = '0;
    for (int i = 0; i < N; i++) w_act_flat[i*W +: W] = r_act[i];
  end

  assign io_mn.ready      = (r_state == S_IDLE);
  assign io_mn.done       = (r_state == S_DONE);
  assign io_mn.win_valid  = r_win_valid;
  assign io_mn.win_idx    = r_win_idx;
  assign io_mn.win_val    = r_win_val;
  assign io_mn.iter_count = r_iter;
  assign io_mn.timeout    = r_timeout;
  assign io_mn.act_vec    = w_act_flat;
endmodule

// File: tb/tb_maxnet_engine.sv
// Directed bench for maxnet_engine: convergence, trivial vectors, reset, handshake and stall handling.
module tb_maxnet_engine;
  localparam int N = 4, W = 8, EPS_FRAC = 8, ITER_W = 16;
`ifdef MAXNET_TIMEOUT_EN
  localparam int MAX_ITER = 16;
`else
  localparam int MAX_ITER = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  maxnet_if #(.N(N), .W(W), .EPS_FRAC(EPS_FRAC), .ITER_W(ITER_W)) mn();

  maxnet_engine #(.N(N), .W(W), .EPS_FRAC(EPS_FRAC), .ITER_W(ITER_W), .MAX_ITER(MAX_ITER)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_mn (mn)
  );

  function automatic logic [31:0] v4(input int a0, input int a1, input int a2, input int a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a start with eps=0.25; returns sampling in cycle 1 after the accepting edge.
  task automatic start_run(input logic [31:0] vec);
    mn.in_vec = vec;
    mn.eps    = 8'd64;
    mn.start  = 1'b1;
    @(posedge clk);
    #1;
    mn.start  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #3;
    checks++; if (mn.ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", mn.ready); end
    checks++; if (mn.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", mn.done); end
    checks++; if (mn.act_vec !== 32'h0) begin errors++; $display("FAIL rst_act: got %h want 0", mn.act_vec); end
    checks++; if ({mn.win_valid, mn.win_idx, mn.win_val, mn.timeout} !== 12'h0) begin
      errors++; $display("FAIL rst_results: got v=%0b i=%0d val=%0d t=%0b want all 0", mn.win_valid, mn.win_idx, mn.win_val, mn.timeout); end
    checks++; if (mn.iter_count !== 16'd0) begin errors++; $display("FAIL rst_iter: got %0d want 0", mn.iter_count); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_update();
    int dones;
    start_run(v4(10, 20, 30, 40));
    tick(); tick(); tick();
    checks++; if (mn.act_vec !== v4(0, 0, 13, 25)) begin errors++; $display("FAIL mid_act_before_rst: got %h want %h", mn.act_vec, v4(0, 0, 13, 25)); end
    #1 rst = 1'b1;
    #1;
    checks++; if (mn.act_vec !== 32'h0 || mn.iter_count !== 16'd0) begin
      errors++; $display("FAIL mid_rst_clear: act=%h iter=%0d want 0/0", mn.act_vec, mn.iter_count); end
    tick();
    checks++; if (mn.ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %0b want 1", mn.ready); end
    rst = 1'b0;
    dones = 0;
    for (int t = 0; t < 12; t++) begin
      if (mn.done === 1'b1) dones++;
      tick();
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL mid_rst_no_done: got %0d pulses want 0", dones); end
  endtask

  task automatic test_converge();
    logic [31:0] exp_it [4];
    exp_it[0] = v4(0, 0, 13, 25);
    exp_it[1] = v4(0, 0, 7, 22);
    exp_it[2] = v4(0, 0, 2, 21);
    exp_it[3] = v4(0, 0, 0, 21);
    start_run(v4(10, 20, 30, 40));
    checks++; if (mn.ready !== 1'b0 || mn.iter_count !== 16'd0) begin
      errors++; $display("FAIL conv_c1: ready=%0b iter=%0d want 0/0", mn.ready, mn.iter_count); end
    for (int t = 2; t <= 10; t++) begin
      tick();
      if (t % 2 == 1) begin
        checks++; if (mn.act_vec !== exp_it[(t-1)/2 - 1]) begin
          errors++; $display("FAIL conv_act_it%0d: got %h want %h", (t-1)/2, mn.act_vec, exp_it[(t-1)/2 - 1]); end
      end
      if (t < 10) begin
        checks++; if (mn.done !== 1'b0) begin errors++; $display("FAIL conv_early_done c%0d: got 1 want 0", t); end
      end
    end
    checks++; if (mn.done !== 1'b1) begin errors++; $display("FAIL conv_done_c10: got %0b want 1", mn.done); end
    checks++; if (mn.win_valid !== 1'b1 || mn.win_idx !== 2'd3 || mn.win_val !== 8'd21) begin
      errors++; $display("FAIL conv_winner: got v=%0b i=%0d val=%0d want 1/3/21", mn.win_valid, mn.win_idx, mn.win_val); end
    checks++; if (mn.iter_count !== 16'd4 || mn.timeout !== 1'b0) begin
      errors++; $display("FAIL conv_iter: got iter=%0d t=%0b want 4/0", mn.iter_count, mn.timeout); end
    tick();
    checks++; if (mn.ready !== 1'b1 || mn.done !== 1'b0 || mn.win_val !== 8'd21) begin
      errors++; $display("FAIL conv_after: ready=%0b done=%0b val=%0d want 1/0/21", mn.ready, mn.done, mn.win_val); end
  endtask

  task automatic test_trivial();
    start_run(v4(0, 0, 0, 0));
    checks++; if (mn.done !== 1'b0) begin errors++; $display("FAIL zero_c1_done: got 1 want 0"); end
    tick();
    checks++; if (mn.done !== 1'b1 || mn.win_valid !== 1'b0 || mn.win_idx !== 2'd0 || mn.win_val !== 8'd0 || mn.iter_count !== 16'd0) begin
      errors++; $display("FAIL zero_c2: done=%0b v=%0b i=%0d val=%0d iter=%0d want 1/0/0/0/0", mn.done, mn.win_valid, mn.win_idx, mn.win_val, mn.iter_count); end
    tick();
    // start and abort together in IDLE: the start wins
    mn.abort = 1'b1;
    start_run(v4(0, 0, 9, 0));
    mn.abort = 1'b0;
    checks++; if (mn.ready !== 1'b0) begin errors++; $display("FAIL single_accept: ready=%0b want 0", mn.ready); end
    tick();
    checks++; if (mn.done !== 1'b1 || mn.win_valid !== 1'b1 || mn.win_idx !== 2'd2 || mn.win_val !== 8'd9 || mn.iter_count !== 16'd0) begin
      errors++; $display("FAIL single_c2: done=%0b v=%0b i=%0d val=%0d iter=%0d want 1/1/2/9/0", mn.done, mn.win_valid, mn.win_idx, mn.win_val, mn.iter_count); end
    tick();
  endtask

  task automatic test_handshake_back_to_back();
    start_run(v4(10, 20, 30, 40));
    tick();
    mn.start  = 1'b1;
    mn.in_vec = v4(0, 0, 9, 0);
    tick();
    checks++; if (mn.act_vec !== v4(0, 0, 13, 25)) begin errors++; $display("FAIL hs_ignore_act: got %h want %h", mn.act_vec, v4(0, 0, 13, 25)); end
    tick();
    mn.start = 1'b0;
    for (int t = 5; t <= 10; t++) tick();
    checks++; if (mn.done !== 1'b1 || mn.win_idx !== 2'd3 || mn.win_val !== 8'd21 || mn.iter_count !== 16'd4) begin
      errors++; $display("FAIL hs_result: done=%0b i=%0d val=%0d iter=%0d want 1/3/21/4", mn.done, mn.win_idx, mn.win_val, mn.iter_count); end
    tick();
    start_run(v4(0, 0, 9, 0));
    checks++; if (mn.win_valid !== 1'b0 || mn.win_val !== 8'd0 || mn.win_idx !== 2'd0 || mn.iter_count !== 16'd0) begin
      errors++; $display("FAIL b2b_cleared: v=%0b i=%0d val=%0d iter=%0d want 0/0/0/0", mn.win_valid, mn.win_idx, mn.win_val, mn.iter_count); end
    tick();
    checks++; if (mn.done !== 1'b1 || mn.win_valid !== 1'b1 || mn.win_idx !== 2'd2 || mn.win_val !== 8'd9) begin
      errors++; $display("FAIL b2b_result: done=%0b v=%0b i=%0d val=%0d want 1/1/2/9", mn.done, mn.win_valid, mn.win_idx, mn.win_val); end
    tick();
  endtask

  task automatic test_stall();
    int dones;
    dones = 0;
    start_run(v4(50, 50, 0, 0));
`ifdef MAXNET_TIMEOUT_EN
    for (int t = 2; t <= 34; t++) begin
      tick();
      if (t == 23) begin
        checks++; if (mn.act_vec !== v4(3, 3, 0, 0) || mn.iter_count !== 16'd11) begin
          errors++; $display("FAIL stall_it11: act=%h iter=%0d want %h/11", mn.act_vec, mn.iter_count, v4(3, 3, 0, 0)); end
      end
      if (t < 34 && mn.done === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL to_early_done: got %0d pulses want 0", dones); end
    checks++; if (mn.done !== 1'b1 || mn.timeout !== 1'b1 || mn.iter_count !== 16'd16) begin
      errors++; $display("FAIL to_done_c34: done=%0b t=%0b iter=%0d want 1/1/16", mn.done, mn.timeout, mn.iter_count); end
    checks++; if (mn.win_valid !== 1'b1 || mn.win_idx !== 2'd0 || mn.win_val !== 8'd3) begin
      errors++; $display("FAIL to_winner: v=%0b i=%0d val=%0d want 1/0/3", mn.win_valid, mn.win_idx, mn.win_val); end
    tick();
`else
    for (int t = 2; t <= 100; t++) begin
      tick();
      if (mn.done === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL stall_no_done: got %0d pulses want 0", dones); end
    checks++; if (mn.act_vec !== v4(3, 3, 0, 0) || mn.iter_count !== 16'd49) begin
      errors++; $display("FAIL stall_c100: act=%h iter=%0d want %h/49", mn.act_vec, mn.iter_count, v4(3, 3, 0, 0)); end
    mn.abort = 1'b1;
    tick();
    mn.abort = 1'b0;
    checks++; if (mn.ready !== 1'b1 || mn.done !== 1'b0 || mn.iter_count !== 16'd49 || mn.timeout !== 1'b0) begin
      errors++; $display("FAIL abort_c101: ready=%0b done=%0b iter=%0d t=%0b want 1/0/49/0", mn.ready, mn.done, mn.iter_count, mn.timeout); end
    dones = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (mn.done === 1'b1) dones++;
    end
    checks++; if (dones !== 0 || mn.iter_count !== 16'd49 || mn.win_valid !== 1'b0 || mn.act_vec !== v4(3, 3, 0, 0)) begin
      errors++; $display("FAIL abort_frozen: dones=%0d iter=%0d v=%0b act=%h want 0/49/0/%h", dones, mn.iter_count, mn.win_valid, mn.act_vec, v4(3, 3, 0, 0)); end
`endif
  endtask

  initial begin
    mn.start  = 1'b0;
    mn.abort  = 1'b0;
    mn.eps    = '0;
    mn.in_vec = '0;
    test_reset();
    test_converge();
    test_trivial();
    test_handshake_back_to_back();
    test_stall();
    test_reset_mid_update();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/maxnet_engine.md
# maxnet_engine

- Parametrised Maxnet winner-take-all engine: N-channel controller and datapath in one block.
- Latches an activation vector, then iterates a_i ← max(0, a_i − ε·Σ_{j≠i} a_j) until at most one activation is nonzero.
- Reports winner index and value, iteration count and termination status.
- Sits between the activation source and the classification result register; replaces the fixed-size write/multiply sequencing controller.

## Interface
- N, 4: channel count, N ≥ 2
- W, 8: activation width, unsigned
- EPS_FRAC, 8: ε is an unsigned fraction with EPS_FRAC fractional bits, ε < 1
- ITER_W, 16: width of iteration counter
- MAX_ITER, 255: iteration limit; only used with MAXNET_TIMEOUT_EN; must be < 2^ITER_W
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; accepted only while ready=1
- abort  in  1  synchronous abort of a running computation
- eps  in  EPS_FRAC  inhibition weight ε = eps/2^EPS_FRAC; sampled on start acceptance
- in_vec  in  N*W  initial activations; channel i at [i*W +: W]; sampled on start acceptance
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse in DONE
- win_valid  out  1  exactly one nonzero activation at termination, or timeout winner
- win_idx  out  $clog2(N)  winner channel
- win_val  out  W  winner activation
- iter_count  out  ITER_W  completed UPDATE iterations
- timeout  out  1  terminated by the iteration limit
- act_vec  out  N*W  current activation registers

## Operation
- States: IDLE, CHECK, UPDATE, DONE.
- IDLE: ready=1. On start, latch in_vec→act_vec and eps, clear iter_count and all result outputs, go to CHECK.
- CHECK: count nonzero activations.
  - Count ≤ 1 → DONE.
  - Else, with the macro and iter_count==MAX_ITER → DONE with timeout=1.
  - Else → UPDATE.
- UPDATE: all channels update in parallel from the old values, then iter_count+1, then → CHECK.
  - S_i = Σ_{j≠i} a_j, width W+$clog2(N).
  - P_i = (eps·S_i) >> EPS_FRAC, truncated.
  - a_i' = (P_i ≥ a_i) ? 0 : a_i − P_i.
  - No overflow is possible; no rounding.
- DONE: done=1 for one cycle, then → IDLE. Results are registered on the CHECK→DONE transition and held until the next accepted start.
  - Count 1: win_valid=1, win_idx = the nonzero channel, win_val = its value.
  - Count 0 (all zero or equal maxima annihilated): win_valid=0, win_idx=0, win_val=0.
  - Timeout: win_valid=1, win_idx = lowest index holding the maximum, win_val = that maximum.
- start is ignored outside IDLE.
- abort in CHECK or UPDATE:
  - Next state is IDLE; no done pulse.
  - act_vec and iter_count are frozen; results stay cleared.
  - abort has priority over a convergence decision.
  - abort is ignored in IDLE and DONE.
- Simultaneous start and abort in IDLE: the start is accepted.

## Timing
- Reset: state IDLE. ready=1; done, win_valid, win_idx, win_val, iter_count, timeout and act_vec all 0.
- rst mid-operation: immediate return to reset values; no done pulse.
- Start accepted at edge E0. CHECK runs in cycle 1, and each iteration adds two cycles.
- With k iterations, done is high during cycle 2+2k after E0; ready returns in the following cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- MAXNET_TIMEOUT_EN defined: the MAX_ITER limit and the timeout output are active.
- MAXNET_TIMEOUT_EN undefined:
  - timeout is tied to 0 and the MAX_ITER comparator is removed.
  - Truncation stalls (equal maxima with P_i=0) then run indefinitely; abort or rst is the only exit.

## Test plan
- Test-plan parameters, unless stated otherwise: N=4, W=8, EPS_FRAC=8, eps=64 (ε=0.25).
- Reset: assert rst mid-UPDATE → all outputs at reset values, ready=1 next cycle, no done pulse.
- in_vec={10,20,30,40} (ch0..3) → act_vec after iterations 1–4 = {0,0,13,25}, {0,0,7,22}, {0,0,2,21}, {0,0,0,21}. Then done in cycle 10, win_valid=1, win_idx=3, win_val=21, iter_count=4, timeout=0.
- in_vec={0,0,0,0} → done in cycle 2, win_valid=0, iter_count=0. in_vec={0,0,9,0} → done in cycle 2, win_idx=2, win_val=9, iter_count=0.
- Timeout stall, with MAXNET_TIMEOUT_EN and MAX_ITER=16: in_vec={50,50,0,0} → activations stall at {3,3,0,0} after iteration 11. Then done in cycle 34, timeout=1, win_valid=1, win_idx=0, win_val=3, iter_count=16.
- Same stall vector, macro undefined: no done pulse within 100 cycles; abort → ready=1 next cycle, no done, iter_count frozen.
- Handshake: start pulsed during CHECK/UPDATE → ignored, results unchanged. Back-to-back start in the cycle after done → accepted, results cleared.
